sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's 8x8 single-clock FIFO.
- Generalises data width and depth.
- Guards writes on full and reads on empty; illegal attempts set sticky error flags.
- Adds almost-full/almost-empty thresholds, occupancy count, synchronous flush and a read-valid strobe.
- Sits between producer/consumer blocks in one clock domain as a rate-decoupling buffer.

---
 rtl/sync_fifo_param.sv | 147 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy flags.
// Build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic                     full_o,
    output logic                     almost_full_o,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    output logic                     empty_o,
    output logic                     almost_empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_L = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_L   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_L   = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PONE   = PTR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              wr_acc;
    logic              rd_acc;

    // Flags decode the registered occupancy only.
    always_comb begin
        full_o         = (count_q == FULL_L);
        empty_o        = (count_q == '0);
        almost_full_o  = (count_q >= AF_L);
        almost_empty_o = (count_q <= AE_L);
        count_o        = count_q;
        overflow_o     = ovf_q;
        underflow_o    = udf_q;
    end

    // Accept qualifiers; a flush swallows both requests.
    always_comb begin
        wr_acc = wr_en_i & ~full_o & ~flush_i;
        rd_acc = rd_en_i & ~empty_o & ~flush_i;
    end

    // Pointer, occupancy and sticky error next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_en_i & full_o);
        udf_d    = udf_q | (rd_en_i & empty_o);
        if (wr_acc) wr_ptr_d = wr_ptr_q + PONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PONE;
        unique case (1'b1)
            flush_i:           count_d = '0;
            wr_acc & ~rd_acc:  count_d = count_q + ONE;
            rd_acc & ~wr_acc:  count_d = count_q - ONE;
            default:           count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem_q[wr_ptr_q] <= data_i;
    end

`ifdef SYNC_FIFO_FWFT_EN

    // Head word is always presented; valid follows occupancy.
    always_comb begin
        data_o  = mem_q[rd_ptr_q];
        valid_o = ~empty_o;
    end

`else

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    // Registered read port with one cycle of latency.
    always_comb begin
        data_d  = data_q;
        valid_d = rd_acc;
        if (rd_acc) data_d = mem_q[rd_ptr_q];
    end

    // Read data and strobe registers; flush keeps the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Drive read port from its registers.
    always_comb begin
        data_o  = data_q;
        valid_o = valid_q;
    end

`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param.
// Queue model tracks contents, count, sticky errors and read port.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          wr_en_i;
    logic [DW-1:0] data_i;
    logic          full_o;
    logic          almost_full_o;
    logic          rd_en_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          empty_o;
    logic          almost_empty_o;
    logic [3:0]    count_o;
    logic          overflow_o;
    logic          underflow_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [$];
    bit            movf;
    bit            mudf;
    logic [DW-1:0] mlast;
    int            max_cnt;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush_i(flush_i),
        .wr_en_i(wr_en_i),
        .data_i(data_i),
        .full_o(full_o),
        .almost_full_o(almost_full_o),
        .rd_en_i(rd_en_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .empty_o(empty_o),
        .almost_empty_o(almost_empty_o),
        .count_o(count_o),
        .overflow_o(overflow_o),
        .underflow_o(underflow_o)
    );

    // One clock of stimulus, model update and output comparison.
    task automatic step(input bit r, input bit fl, input bit wr,
                        input logic [DW-1:0] wd, input bit rd);
        bit aw;
        bit ar;
        int n;
        rst     = r;
        flush_i = fl;
        wr_en_i = wr;
        data_i  = wd;
        rd_en_i = rd;
        aw = wr && !r && !fl && (mq.size() < D);
        ar = rd && !r && !fl && (mq.size() > 0);
        if (r) begin
            mq.delete();
            movf  = 1'b0;
            mudf  = 1'b0;
            mlast = '0;
        end else if (fl) begin
            mq.delete();
            movf = 1'b0;
            mudf = 1'b0;
        end else begin
            if (wr && mq.size() == D) movf = 1'b1;
            if (rd && mq.size() == 0) mudf = 1'b1;
            if (ar) mlast = mq.pop_front();
            if (aw) mq.push_back(wd);
        end
        @(posedge clk);
        #1;
        n = mq.size();
        if (n > max_cnt) max_cnt = n;
        checks++;
        if (count_o !== 4'(n)) begin
            errors++;
            $display("FAIL count_o got %0d exp %0d t=%0t", count_o, n, $time);
        end
        checks++;
        if (full_o !== (n == D)) begin
            errors++;
            $display("FAIL full_o got %b exp %b t=%0t", full_o, n == D, $time);
        end
        checks++;
        if (empty_o !== (n == 0)) begin
            errors++;
            $display("FAIL empty_o got %b exp %b t=%0t", empty_o, n == 0, $time);
        end
        checks++;
        if (almost_full_o !== (n >= AF)) begin
            errors++;
            $display("FAIL almost_full_o got %b exp %b t=%0t",
                     almost_full_o, n >= AF, $time);
        end
        checks++;
        if (almost_empty_o !== (n <= AE)) begin
            errors++;
            $display("FAIL almost_empty_o got %b exp %b t=%0t",
                     almost_empty_o, n <= AE, $time);
        end
        checks++;
        if (overflow_o !== movf) begin
            errors++;
            $display("FAIL overflow_o got %b exp %b t=%0t", overflow_o, movf, $time);
        end
        checks++;
        if (underflow_o !== mudf) begin
            errors++;
            $display("FAIL underflow_o got %b exp %b t=%0t", underflow_o, mudf, $time);
        end
`ifdef SYNC_FIFO_FWFT_EN
        checks++;
        if (valid_o !== (n != 0)) begin
            errors++;
            $display("FAIL valid_o got %b exp %b t=%0t", valid_o, n != 0, $time);
        end
        if (n != 0) begin
            checks++;
            if (data_o !== mq[0]) begin
                errors++;
                $display("FAIL data_o got %h exp %h t=%0t", data_o, mq[0], $time);
            end
        end
`else
        checks++;
        if (valid_o !== ar) begin
            errors++;
            $display("FAIL valid_o got %b exp %b t=%0t", valid_o, ar, $time);
        end
        checks++;
        if (data_o !== mlast) begin
            errors++;
            $display("FAIL data_o got %h exp %h t=%0t", data_o, mlast, $time);
        end
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hBB, 1'b1);
        idle();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) step(1'b0, 1'b0, 1'b1, 8'(i * 17), 1'b0);
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        idle();
    endtask

    task automatic test_drain();
        for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
    endtask

    task automatic test_full_wr_rd();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        test_fill();
        step(1'b0, 1'b0, 1'b1, 8'hE7, 1'b1);
        test_drain();
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 4; i < 20; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'b0, ($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
                 8'($urandom), $urandom_range(0, 1) == 1);
        end
        checks++;
        if (max_cnt > D) begin
            errors++;
            $display("FAIL max_count got %0d exp <=%0d", max_cnt, D);
        end
    endtask

    task automatic test_flush();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hC3, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'hC4, 1'b1);
        idle();
        step(1'b0, 1'b0, 1'b1, 8'hD1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
    endtask

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        wr_en_i = 1'b0;
        data_i  = '0;
        rd_en_i = 1'b0;
        movf    = 1'b0;
        mudf    = 1'b0;
        mlast   = '0;
        max_cnt = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_full_wr_rd();
        test_wrap();
        test_random();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
